// File: rtl/vdec_hs_crc_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vdec_hs_crc_sched_if                                            |
// | Purpose  : Bundles the requester-side and engine-side signals of the HS    |
// |            CRC check scheduler.                                            |
// |            slave  modport : the scheduler itself                           |
// |            master modport : requesters and the CRC engine around it        |
// | Signals  : req/req_bits/req_len  requester levels and per-slot operands    |
// |            gnt/rsp_vld           one-hot acceptance and result pulses      |
// |            rsp_match/rsp_err     result qualifiers (valid with rsp_vld)    |
// |            eng_*                 CRC engine launch and completion          |
// |            sched_busy            scheduler is not idle                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface vdec_hs_crc_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 37,
    parameter int LEN_W   = 6
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_bits;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_vld;
    logic                      rsp_match;
    logic                      rsp_err;
    logic                      eng_start;
    logic [DATA_W-1:0]         eng_bits;
    logic [LEN_W-1:0]          eng_len;
    logic                      eng_done;
    logic                      eng_match;
    logic                      eng_busy;
    logic                      sched_busy;

    modport slave (
        input  req,
        input  req_bits,
        input  req_len,
        output gnt,
        output rsp_vld,
        output rsp_match,
        output rsp_err,
        output eng_start,
        output eng_bits,
        output eng_len,
        input  eng_done,
        input  eng_match,
        input  eng_busy,
        output sched_busy
    );

    modport master (
        output req,
        output req_bits,
        output req_len,
        input  gnt,
        input  rsp_vld,
        input  rsp_match,
        input  rsp_err,
        input  eng_start,
        input  eng_bits,
        input  eng_len,
        output eng_done,
        output eng_match,
        output eng_busy,
        input  sched_busy
    );

endinterface
`default_nettype wire

// File: rtl/vdec_hs_crc_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vdec_hs_crc_sched                                               |
// | Purpose  : Round-robin scheduler sharing one serial HS CRC check engine    |
// |            between NUM_REQ requesters. One request in flight at a time;    |
// |            illegal lengths are rejected without starting the engine and a  |
// |            watchdog aborts a request whose engine never reports done.      |
// | Ports    : clk, rst   clock and synchronous active-high reset              |
// |            bus        vdec_hs_crc_sched_if.slave (requests, grants,        |
// |                       responses, engine launch/done, sched_busy)           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module vdec_hs_crc_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 37,
    parameter int LEN_W   = 6,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    vdec_hs_crc_sched_if.slave bus
);

    localparam int                 PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                 WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0]   C_PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]    C_WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]    C_WD_ONE   = WD_W'(1);
    localparam logic [NUM_REQ-1:0] C_ONE_HOT0 = NUM_REQ'(1);

    // S_LAUNCH is the grant cycle: gnt/eng_start are visible while the
    // length check result decides between waiting and the error response,
    // which places an error response one cycle after the grant.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT     = 3'd2,
        S_RESP     = 3'd3,
        S_RESP_ERR = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]    win_q,       win_d;
    logic [WD_W-1:0]     wdog_q,      wdog_d;
    logic                match_q,     match_d;
    logic                len_bad_q,   len_bad_d;
    logic [NUM_REQ-1:0]  gnt_q,       gnt_d;
    logic                eng_start_q, eng_start_d;
    logic [DATA_W-1:0]   eng_bits_q,  eng_bits_d;
    logic [LEN_W-1:0]    eng_len_q,   eng_len_d;

    logic                w_found;
    logic [PTR_W-1:0]    w_win_idx;
    int                  w_cand;
    logic [PTR_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_bits_sel;
    logic [LEN_W-1:0]    w_len_sel;
    logic                w_len_bad;

    // ------------------------------------------------------------------
    // Round-robin search: start one past the last winner and wrap, so the
    // most recently served requester has the lowest priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_cand    = 0;
        w_idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(rr_ptr_q) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_idx = PTR_W'(w_cand);
            if (!w_found && bus.req[w_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_idx;
            end
        end
    end

    // Operand mux for the winning slot
    always_comb begin
        w_bits_sel = '0;
        w_len_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == PTR_W'(i)) begin
                w_bits_sel = bus.req_bits[i*DATA_W +: DATA_W];
                w_len_sel  = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // A zero length or one longer than the check word cannot be checked
    assign w_len_bad = (w_len_sel == '0) || (int'(w_len_sel) > DATA_W);

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        wdog_d      = wdog_q;
        match_d     = match_q;
        len_bad_d   = len_bad_q;
        gnt_d       = '0;
        eng_start_d = 1'b0;
        eng_bits_d  = eng_bits_q;
        eng_len_d   = eng_len_q;

        case (state_q)
            S_IDLE: begin
                // A done pulse seen here belongs to an aborted request and
                // is deliberately ignored.
                if (w_found && !bus.eng_busy) begin
                    state_d     = S_LAUNCH;
                    rr_ptr_d    = w_win_idx;
                    win_d       = w_win_idx;
                    gnt_d       = C_ONE_HOT0 << w_win_idx;
                    eng_bits_d  = w_bits_sel;
                    eng_len_d   = w_len_sel;
                    len_bad_d   = w_len_bad;
                    eng_start_d = !w_len_bad;
                    match_d     = 1'b0;
                    wdog_d      = '0;
                end
            end

            S_LAUNCH: begin
                // The engine needs at least two cycles after its start
                // pulse, so no done can be due here.
                if (len_bad_q) begin
                    state_d = S_RESP_ERR;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // Done takes precedence over a watchdog expiry in the same cycle
                if (bus.eng_done) begin
                    match_d = bus.eng_match;
                    wdog_d  = '0;
                    state_d = S_RESP;
                end else if (wdog_q == C_WD_LIMIT) begin
                    wdog_d  = '0;
                    state_d = S_RESP_ERR;
                end else begin
                    wdog_d  = wdog_q + C_WD_ONE;
                end
            end

            S_RESP:     state_d = S_IDLE;
            S_RESP_ERR: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= C_PTR_RST;
            win_q       <= '0;
            wdog_q      <= '0;
            match_q     <= 1'b0;
            len_bad_q   <= 1'b0;
            gnt_q       <= '0;
            eng_start_q <= 1'b0;
            eng_bits_q  <= '0;
            eng_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
            wdog_q      <= wdog_d;
            match_q     <= match_d;
            len_bad_q   <= len_bad_d;
            gnt_q       <= gnt_d;
            eng_start_q <= eng_start_d;
            eng_bits_q  <= eng_bits_d;
            eng_len_q   <= eng_len_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: response pulses decode straight from the response states,
    // so they are zero in every other state without extra flops.
    // ------------------------------------------------------------------
    assign bus.gnt        = gnt_q;
    assign bus.eng_start  = eng_start_q;
    assign bus.eng_bits   = eng_bits_q;
    assign bus.eng_len    = eng_len_q;
    assign bus.rsp_vld    = ((state_q == S_RESP) || (state_q == S_RESP_ERR))
                            ? (C_ONE_HOT0 << win_q) : '0;
    assign bus.rsp_match  = (state_q == S_RESP) && match_q;
    assign bus.rsp_err    = (state_q == S_RESP_ERR);
    assign bus.sched_busy = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vdec_hs_crc_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vdec_hs_crc_sched                                            |
// | Purpose  : Directed self-checking bench for vdec_hs_crc_sched with a       |
// |            behavioural CRC engine and grant/response scoreboards.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vdec_hs_crc_sched;

    localparam int NR = 4;
    localparam int DW = 37;
    localparam int LW = 6;
    localparam int TO = 63;

    typedef struct {
        int            idx;
        int            cyc;
        logic          start;
        logic [LW-1:0] len;
        logic [DW-1:0] bits;
    } gexp_t;

    typedef struct {
        int   idx;
        int   cyc;
        logic match;
        logic err;
    } rexp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    logic mon_en;
    logic hang;

    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t mg;
    rexp_t mr;
    logic [NR-1:0] exp_oh;

    vdec_hs_crc_sched_if #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) bus ();

    vdec_hs_crc_sched #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .LEN_W   (LW),
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- CRC helpers (CRC-16/CCITT, LSB first) ----------------
    function automatic logic [15:0] crc16(input logic [DW-1:0] w, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            fb = w[i] ^ c[15];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [DW-1:0] make_word(input logic [DW-1:0] info, input int l);
        logic [DW-1:0] w;
        logic [15:0]   c;
        w = '0;
        for (int i = 0; i < l - 16; i++) w[i] = info[i];
        c = crc16(w, l - 16);
        for (int k = 0; k < 16; k++) w[l - 16 + k] = c[k];
        return w;
    endfunction

    function automatic logic crc_ok(input logic [DW-1:0] w, input int l);
        logic [15:0] c;
        if (l < 17 || l > DW) return 1'b0;
        c = crc16(w, l - 16);
        for (int k = 0; k < 16; k++) begin
            if (w[l - 16 + k] != c[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- Engine model: done L+1 cycles after start ----------------
    logic       e_busy;
    logic [7:0] e_cnt;
    logic       e_match;

    always @(posedge clk) begin
        if (rst) begin
            e_busy  <= 1'b0;
            e_cnt   <= 8'd0;
            e_match <= 1'b0;
        end else if (bus.eng_start) begin
            e_busy  <= 1'b1;
            e_cnt   <= hang ? 8'd80 : {2'b00, bus.eng_len};
            e_match <= crc_ok(bus.eng_bits, int'(bus.eng_len));
        end else if (e_busy && e_cnt == 8'd0) begin
            e_busy  <= 1'b0;
        end else if (e_busy) begin
            e_cnt   <= e_cnt - 8'd1;
        end
    end

    assign bus.eng_done  = e_busy && (e_cnt == 8'd0);
    assign bus.eng_match = e_busy && (e_cnt == 8'd0) && e_match;
    assign bus.eng_busy  = e_busy;

    // ---------------- Check and stimulus helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_g(input int idx, input int c, input logic s,
                          input logic [LW-1:0] l, input logic [DW-1:0] b);
        gexp_t e;
        e.idx = idx; e.cyc = c; e.start = s; e.len = l; e.bits = b;
        gq.push_back(e);
    endtask

    task automatic push_r(input int idx, input int c, input logic m, input logic er);
        rexp_t e;
        e.idx = idx; e.cyc = c; e.match = m; e.err = er;
        rq.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] w, input logic [LW-1:0] l);
        bus.req_bits[i*DW +: DW] = w;
        bus.req_len[i*LW +: LW]  = l;
        bus.req[i]               = 1'b1;
    endtask

    task automatic clr_req(input int i);
        bus.req[i] = 1'b0;
    endtask

    task automatic tick_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- Output monitor / scoreboard pop ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.gnt != '0 || bus.eng_start) begin
                chk("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
                chk("gnt_pending", 64'(gq.size() > 0), 64'd1);
                if (gq.size() > 0) begin
                    mg     = gq.pop_front();
                    exp_oh = NR'(1) << mg.idx;
                    chk("gnt_idx", 64'(bus.gnt), 64'(exp_oh));
                    chk("gnt_cycle", 64'(cyc), 64'(mg.cyc));
                    chk("eng_start", 64'(bus.eng_start), 64'(mg.start));
                    chk("eng_len", 64'(bus.eng_len), 64'(mg.len));
                    chk("eng_bits", 64'(bus.eng_bits), 64'(mg.bits));
                    chk("busy_at_gnt", 64'(bus.sched_busy), 64'd1);
                end
            end
            if (bus.rsp_vld != '0) begin
                chk("rsp_pending", 64'(rq.size() > 0), 64'd1);
                if (rq.size() > 0) begin
                    mr     = rq.pop_front();
                    exp_oh = NR'(1) << mr.idx;
                    chk("rsp_idx", 64'(bus.rsp_vld), 64'(exp_oh));
                    chk("rsp_cycle", 64'(cyc), 64'(mr.cyc));
                    chk("rsp_match", 64'(bus.rsp_match), 64'(mr.match));
                    chk("rsp_err", 64'(bus.rsp_err), 64'(mr.err));
                    chk("busy_at_rsp", 64'(bus.sched_busy), 64'd1);
                end
            end else begin
                chk("rsp_flags_quiet", 64'({bus.rsp_match, bus.rsp_err}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- Directed sequence ----------------
    logic [DW-1:0] w21a;
    logic [DW-1:0] w21b;
    int            t;

    initial begin
        checks       = 0;
        errors       = 0;
        mon_en       = 1'b0;
        hang         = 1'b0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_bits = '0;
        bus.req_len  = '0;
        w21a         = make_word(37'h16, 21);
        w21b         = make_word(37'h0B, 21);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt",       64'(bus.gnt),        64'd0);
        chk("rst_rsp_vld",   64'(bus.rsp_vld),    64'd0);
        chk("rst_rsp_match", 64'(bus.rsp_match),  64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),    64'd0);
        chk("rst_eng_start", 64'(bus.eng_start),  64'd0);
        chk("rst_eng_bits",  64'(bus.eng_bits),   64'd0);
        chk("rst_eng_len",   64'(bus.eng_len),    64'd0);
        chk("rst_busy",      64'(bus.sched_busy), 64'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // All four requesters held: rotation 0,1,2,3,0,1 at L+4 spacing
        t = cyc;
        for (int i = 0; i < NR; i++) set_req(i, DW'(37'h100 + i), 6'd6);
        for (int k = 0; k < 6; k++) begin
            push_g(k % NR, t + 1 + 10*k, 1'b1, 6'd6, DW'(37'h100 + (k % NR)));
            push_r(k % NR, t + 9 + 10*k, 1'b0, 1'b0);
        end
        tick_to(t + 52);
        bus.req = '0;
        tick_to(t + 62);

        // Single legal request with valid CRC, L=21
        t = cyc;
        set_req(0, w21a, 6'd21);
        push_g(0, t + 1, 1'b1, 6'd21, w21a);
        push_r(0, t + 24, 1'b1, 1'b0);
        tick_to(t + 2);
        clr_req(0);
        tick_to(t + 27);

        // Illegal lengths: 0 and 40 -> error one cycle after grant, no start
        t = cyc;
        set_req(1, 37'h1ABCD, 6'd0);
        push_g(1, t + 1, 1'b0, 6'd0, 37'h1ABCD);
        push_r(1, t + 2, 1'b0, 1'b1);
        tick_to(t + 2);
        clr_req(1);
        tick_to(t + 4);
        t = cyc;
        set_req(1, 37'h0F0F0, 6'd40);
        push_g(1, t + 1, 1'b0, 6'd40, 37'h0F0F0);
        push_r(1, t + 2, 1'b0, 1'b1);
        tick_to(t + 2);
        clr_req(1);
        tick_to(t + 4);

        // Hung engine: watchdog abort, stale done later, grant held off while busy
        hang = 1'b1;
        t = cyc;
        set_req(3, w21b, 6'd21);
        push_g(3, t + 1, 1'b1, 6'd21, w21b);
        push_r(3, t + 2 + TO, 1'b0, 1'b1);
        tick_to(t + 2);
        clr_req(3);
        tick_to(t + 70);
        set_req(2, 37'h2A, 6'd6);
        push_g(2, t + 84, 1'b1, 6'd6, 37'h2A);
        push_r(2, t + 92, 1'b0, 1'b0);
        tick_to(t + 82);
        @(negedge clk);
        chk("stale_done_rsp", 64'(bus.rsp_vld), 64'd0);
        chk("stale_done_busy", 64'(bus.sched_busy), 64'd0);
        chk("no_gnt_eng_busy", 64'(bus.gnt), 64'd0);
        @(posedge clk);
        #1;
        hang = 1'b0;
        @(negedge clk);
        chk("stale_after_rsp", 64'(bus.rsp_vld), 64'd0);
        chk("stale_after_busy", 64'(bus.sched_busy), 64'd0);
        tick_to(t + 85);
        clr_req(2);
        tick_to(t + 95);

        // Two simultaneous requesters with corrupted words, L=6
        t = cyc;
        set_req(0, w21a ^ 37'h1, 6'd6);
        set_req(2, w21b ^ 37'h4, 6'd6);
        push_g(0, t + 1, 1'b1, 6'd6, w21a ^ 37'h1);
        push_r(0, t + 9, 1'b0, 1'b0);
        push_g(2, t + 11, 1'b1, 6'd6, w21b ^ 37'h4);
        push_r(2, t + 19, 1'b0, 1'b0);
        tick_to(t + 2);
        clr_req(0);
        tick_to(t + 12);
        clr_req(2);
        tick_to(t + 22);

        // Reset mid-flight (L=37), then arbitration restarts from requester 0
        t = cyc;
        set_req(2, 37'h1F_0000_0001, 6'd37);
        push_g(2, t + 1, 1'b1, 6'd37, 37'h1F_0000_0001);
        tick_to(t + 2);
        clr_req(2);
        tick_to(t + 11);
        rst = 1'b1;
        tick_to(t + 12);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_gnt",       64'(bus.gnt),        64'd0);
        chk("mid_rst_rsp_vld",   64'(bus.rsp_vld),    64'd0);
        chk("mid_rst_rsp_match", 64'(bus.rsp_match),  64'd0);
        chk("mid_rst_rsp_err",   64'(bus.rsp_err),    64'd0);
        chk("mid_rst_eng_start", 64'(bus.eng_start),  64'd0);
        chk("mid_rst_eng_bits",  64'(bus.eng_bits),   64'd0);
        chk("mid_rst_eng_len",   64'(bus.eng_len),    64'd0);
        chk("mid_rst_busy",      64'(bus.sched_busy), 64'd0);
        @(posedge clk);
        #1;
        set_req(2, w21b, 6'd21);
        set_req(3, 37'h3C, 6'd6);
        push_g(2, t + 14, 1'b1, 6'd21, w21b);
        push_r(2, t + 37, 1'b1, 1'b0);
        push_g(3, t + 39, 1'b1, 6'd6, 37'h3C);
        push_r(3, t + 47, 1'b0, 1'b0);
        tick_to(t + 15);
        clr_req(2);
        tick_to(t + 40);
        clr_req(3);
        tick_to(t + 55);

        @(negedge clk);
        chk("gnt_queue_drained", 64'(gq.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
